// File: rtl/btn_pkg.sv
// btn_pkg: shared types and default constants for the button front end.
//   btn_state_t      - per-channel debounce FSM state
//   BTN_DEBOUNCE_DEF - default debounce length (5 ms at 100 MHz)
//   BTN_LONG_DEF     - default long-press hold length (1 s at 100 MHz)
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HELD      = 2'd2,
    FALL_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_DEBOUNCE_DEF = 500000;
  localparam int BTN_LONG_DEF     = 100000000;

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- 2-FF synchroniser, debounce FSM with
// down-to-terminal compare on an up-counter, press/release strobes, toggle,
// and (when BTN_LONGPRESS_EN is defined) a long-press hold counter.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   btn        - raw asynchronous button pin, active-high
//   level_o    - debounced level
//   press_o    - one-cycle strobe on debounced rising edge
//   release_o  - one-cycle strobe on debounced falling edge
//   toggle_o   - flips on every debounced press
//   long_o     - one-cycle strobe after LONG_CYCLES of hold (0 if compiled out)
//
// state     | meaning
// IDLE      | level 0, synchronised input 0
// RISE_WAIT | level 0, input 1, counting stable cycles
// HELD      | level 1, input 1
// FALL_WAIT | level 1, input 0, counting stable cycles
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = BTN_LONG_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic long_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  btn_state_t    state;
  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt;
  logic          s;
  logic          rise_done;
  logic          fall_done;

  assign s         = sync_q[1];
  assign rise_done = (state == RISE_WAIT) && s  && (db_cnt == DB_LAST);
  assign fall_done = (state == FALL_WAIT) && !s && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync_q    <= 2'b00;
      db_cnt    <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      toggle_o  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn};
      press_o   <= 1'b0;
      release_o <= 1'b0;
      case (state)
        IDLE: begin
          db_cnt <= '0;
          if (s) state <= RISE_WAIT;
        end
        RISE_WAIT: begin
          if (!s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (rise_done) begin
            state    <= HELD;
            db_cnt   <= '0;
            level_o  <= 1'b1;
            press_o  <= 1'b1;
            toggle_o <= ~toggle_o;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          db_cnt <= '0;
          if (!s) state <= FALL_WAIT;
        end
        FALL_WAIT: begin
          if (s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (fall_done) begin
            state     <= IDLE;
            db_cnt    <= '0;
            level_o   <= 1'b0;
            release_o <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;

  // Hold time keeps running through release bounces (FALL_WAIT) so a short
  // glitch does not restart the long-press measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      long_o   <= 1'b0;
    end else begin
      long_o <= 1'b0;
      if (rise_done || fall_done) begin
        hold_cnt <= '0;
      end else if (state == HELD || state == FALL_WAIT) begin
        if (hold_cnt == HOLD_LAST) begin
          long_o   <= 1'b1;
          hold_cnt <= HOLD_SAT;
        end else if (hold_cnt < HOLD_LAST) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_ctrl.sv
// btn_ctrl: multi-channel button front end; N_BTN independent btn_channel
// instances sharing clk/rst. Long-press support is built only when
// BTN_LONGPRESS_EN is defined; otherwise long_o is constant 0.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   btn        - raw button pins [N_BTN-1:0], active-high
//   level_o    - debounced levels
//   press_o    - press strobes
//   release_o  - release strobes
//   toggle_o   - per-channel toggle
//   long_o     - long-press strobes
module btn_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = BTN_LONG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] toggle_o,
  output logic [N_BTN-1:0] long_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .toggle_o (toggle_o[i]),
      .long_o   (long_o[i])
    );
  end

endmodule

// File: tb/tb_btn_ctrl.sv
module tb_btn_ctrl;
  localparam int N = 2;
  localparam int DEB = 4;
  localparam int LNG = 10;
`ifdef BTN_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] level_o, press_o, release_o, toggle_o, long_o;
  logic [9:0]   obs;

  btn_ctrl #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .toggle_o (toggle_o),
    .long_o   (long_o)
  );

  always #5 clk = ~clk;
  assign obs = {level_o, press_o, release_o, toggle_o, long_o};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: debounced level flips once the synchronised input has
  // disagreed with it for DEB+1 consecutive samples; long fires when the
  // number of cycles since the press reaches LNG.
  bit   hist1 [N];
  bit   hist2 [N];
  int   run   [N];
  int   since [N];
  logic [N-1:0] m_lev, m_tog, m_p, m_r, m_g;

  function automatic logic [9:0] model_out();
    return {m_lev, m_p, m_r, m_tog, m_g};
  endfunction

  task automatic model_step();
    bit s;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        hist1[c] = 0; hist2[c] = 0; run[c] = 0; since[c] = 0;
      end
      m_lev = '0; m_tog = '0; m_p = '0; m_r = '0; m_g = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        s = hist2[c];
        hist2[c] = hist1[c];
        hist1[c] = btn[c];
        m_p[c] = 1'b0; m_r[c] = 1'b0; m_g[c] = 1'b0;
        run[c] = (s != m_lev[c]) ? run[c] + 1 : 0;
        if (run[c] == DEB + 1) begin
          run[c] = 0;
          m_lev[c] = ~m_lev[c];
          if (m_lev[c]) begin
            m_p[c] = 1'b1;
            m_tog[c] = ~m_tog[c];
            since[c] = 0;
          end else begin
            m_r[c] = 1'b1;
          end
        end else if (m_lev[c]) begin
          since[c]++;
          if (since[c] == LNG && LONG_EN) m_g[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] b);
    @(negedge clk);
    rst = r;
    btn = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [9:0]   exp;
  } vec_t;

  vec_t tbl [30];

  initial begin
    logic l0, p0, r0, t0, g0, b0, b1;
    int period;
    logic [N-1:0] rb;

    // Table: clean press on ch0 (held 20 cycles) alongside a bounce on ch1.
    for (int k = 0; k < 30; k++) begin
      b0 = (k < 20);
      b1 = (k < 3) || (k >= 4 && k < 7);
      l0 = (k >= 6 && k < 26);
      p0 = (k == 6);
      r0 = (k == 26);
      t0 = (k >= 6);
      g0 = LONG_EN && (k == 16);
      tbl[k].rst = 1'b0;
      tbl[k].btn = {b1, b0};
      tbl[k].exp = {1'b0, l0, 1'b0, p0, 1'b0, r0, 1'b0, t0, 1'b0, g0};
    end

    cyc(1'b1, 2'b11);
    check("reset_state", obs, 10'd0);
    cyc(1'b1, 2'b00);
    check("reset_state2", obs, 10'd0);

    for (int k = 0; k < 30; k++) begin
      cyc(tbl[k].rst, tbl[k].btn);
      check($sformatf("table[%0d]", k), obs, tbl[k].exp);
    end

    // Simultaneous press and release on both channels.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 2'b11);
      check($sformatf("simul_press[%0d]", k), {8'd0, press_o}, {8'd0, (k == 6) ? 2'b11 : 2'b00});
    end
    check("simul_toggle", {8'd0, toggle_o}, 10'b10);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 2'b00);
      check($sformatf("simul_release[%0d]", k), {8'd0, release_o}, {8'd0, (k == 6) ? 2'b11 : 2'b00});
    end

    // Two full press/release cycles on ch0; toggle0 currently 0.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 10; k++) begin
        cyc(1'b0, 2'b01);
        check($sformatf("pr%0d_press[%0d]", rep, k), {9'd0, press_o[0]}, {9'd0, k == 6});
      end
      check($sformatf("pr%0d_toggle", rep), {9'd0, toggle_o[0]}, {9'd0, rep == 0});
      for (int k = 0; k < 10; k++) begin
        cyc(1'b0, 2'b00);
        check($sformatf("pr%0d_release[%0d]", rep, k), {9'd0, release_o[0]}, {9'd0, k == 6});
      end
    end

    // Reset while ch0 is held with toggle set; button stays held.
    for (int k = 0; k < 8; k++) cyc(1'b0, 2'b01);
    check("pre_reset_toggle", {9'd0, toggle_o[0]}, 10'd1);
    cyc(1'b1, 2'b01);
    check("mid_reset_outputs", obs, 10'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 2'b01);
      check($sformatf("post_reset[%0d]", k), {8'd0, level_o[0], press_o[0]},
            {8'd0, k >= 6, k == 6});
    end

    // Randomised phase against the model.
    period = 8;
    rb = '0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 40 == 0) period = $urandom_range(2, 30);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, period - 1) == 0) rb[c] = ~rb[c];
      cyc(($urandom_range(0, 799) == 0), rb);
      check($sformatf("random[%0d]", k), obs, model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
